// File: rtl/stat_pkg.sv
// Shared types, stat indices and gain constants for the pet stat scheduler.
package stat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTION = 2'd1,
    ST_DECAY  = 2'd2,
    ST_EVENT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ACT_FEED      = 3'd0,
    ACT_PLAY      = 3'd1,
    ACT_MEDICINE  = 3'd2,
    ACT_CLEAN     = 3'd3,
    ACT_SLEEP     = 3'd4,
    ACT_SOCIALIZE = 3'd5,
    ACT_NOP6      = 3'd6,
    ACT_NOP7      = 3'd7
  } action_e;

  localparam int NUM_STATS     = 6;
  localparam int IDX_HUNGER    = 0;
  localparam int IDX_HAPPINESS = 1;
  localparam int IDX_HEALTH    = 2;
  localparam int IDX_HYGIENE   = 3;
  localparam int IDX_ENERGY    = 4;
  localparam int IDX_SOCIAL    = 5;

  localparam logic [2:0] DECAY_LAST = 3'd5;

  localparam logic [3:0] STAT_INIT      = 4'd8;
  localparam logic [3:0] GAIN_FEED      = 4'd4;
  localparam logic [3:0] GAIN_PLAY      = 4'd4;
  localparam logic [3:0] GAIN_MEDICINE  = 4'd4;
  localparam logic [3:0] GAIN_CLEAN     = 4'd4;
  localparam logic [3:0] GAIN_SLEEP     = 4'd6;
  localparam logic [3:0] GAIN_SOCIALIZE = 4'd4;
  localparam logic [3:0] COST_ENERGY    = 4'd1;
  localparam logic [3:0] DECAY_STEP     = 4'd1;

  // Add with a 5-bit intermediate, clamping at 15.
  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[4] ? 4'd15 : sum[3:0];
  endfunction

  // Subtract with a 5-bit intermediate; a borrow means the result clamps at 0.
  function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[4] ? 4'd0 : diff[3:0];
  endfunction

endpackage

// File: rtl/stat_scheduler_if.sv
// Player action handshake plus the random source feeding the scheduler.
interface stat_scheduler_if;
  logic       action_valid;
  logic [2:0] action_id;
  logic       action_ready;
  logic [7:0] random;

  modport master (output action_valid, output action_id, output random, input action_ready);
  modport slave  (input action_valid, input action_id, input random, output action_ready);
endinterface

// File: rtl/stat_scheduler_tick_prescaler.sv
// Free-running cycle counter producing one decay tick per MAX_COUNT cycles.
module tick_prescaler #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [23:0] count_q;

  // Count 0..MAX_COUNT-1; tick is registered so it pulses for the one cycle after the wrap edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 24'd0;
      tick    <= 1'b0;
    end else if (count_q == MAX_COUNT - 24'd1) begin
      count_q <= 24'd0;
      tick    <= 1'b1;
    end else begin
      count_q <= count_q + 24'd1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/stat_scheduler.sv
// Pet stat scheduler: applies player actions, periodic stat decay and random sickness events.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting; a pending decay wins over a new action
// ST_ACTION | one cycle applying the latched action
// ST_DECAY  | six cycles, one stat decremented per cycle via idx_q
// ST_EVENT  | one cycle of random sickness, health -1
module stat_scheduler #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  stat_scheduler_if.slave         act,
  output logic [3:0]              hunger,
  output logic [3:0]              happiness,
  output logic [3:0]              health,
  output logic [3:0]              hygiene,
  output logic [3:0]              energy,
  output logic [3:0]              social,
  output logic                    busy,
  output logic                    tick
);
  import stat_pkg::*;

  state_e                        state_q;
  action_e                       act_q;
  logic [2:0]                    idx_q;
  logic                          pend_q;
  logic                          busy_q;
  logic [NUM_STATS-1:0][3:0]     stat_q;
  logic                          unused_random_bits;

  tick_prescaler #(.MAX_COUNT(MAX_COUNT)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign act.action_ready   = (state_q == ST_IDLE) && !pend_q;
  assign busy               = busy_q;
  assign unused_random_bits = ^act.random[7:3];

  assign hunger    = stat_q[IDX_HUNGER];
  assign happiness = stat_q[IDX_HAPPINESS];
  assign health    = stat_q[IDX_HEALTH];
  assign hygiene   = stat_q[IDX_HYGIENE];
  assign energy    = stat_q[IDX_ENERGY];
  assign social    = stat_q[IDX_SOCIAL];

  // Scheduler FSM; sole writer of the stat registers. The pending flag clears when IDLE
  // hands off to DECAY, so a tick landing while a decay is already owed is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      act_q   <= ACT_NOP6;
      idx_q   <= 3'd0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NUM_STATS; i++) stat_q[i] <= STAT_INIT;
    end else begin
      if ((state_q == ST_IDLE) && pend_q) pend_q <= 1'b0;
      else if (tick)                      pend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            state_q <= ST_DECAY;
            idx_q   <= 3'd0;
            busy_q  <= 1'b1;
          end else if (act.action_valid) begin
            state_q <= ST_ACTION;
            act_q   <= action_e'(act.action_id);
            busy_q  <= 1'b1;
          end
        end

        ST_ACTION: begin
          case (act_q)
            ACT_FEED:     stat_q[IDX_HUNGER]  <= sat_add(stat_q[IDX_HUNGER], GAIN_FEED);
            ACT_PLAY: begin
              stat_q[IDX_HAPPINESS] <= sat_add(stat_q[IDX_HAPPINESS], GAIN_PLAY);
              stat_q[IDX_ENERGY]    <= sat_sub(stat_q[IDX_ENERGY], COST_ENERGY);
            end
            ACT_MEDICINE: stat_q[IDX_HEALTH]  <= sat_add(stat_q[IDX_HEALTH], GAIN_MEDICINE);
            ACT_CLEAN:    stat_q[IDX_HYGIENE] <= sat_add(stat_q[IDX_HYGIENE], GAIN_CLEAN);
            ACT_SLEEP:    stat_q[IDX_ENERGY]  <= sat_add(stat_q[IDX_ENERGY], GAIN_SLEEP);
            ACT_SOCIALIZE: begin
              stat_q[IDX_SOCIAL] <= sat_add(stat_q[IDX_SOCIAL], GAIN_SOCIALIZE);
              stat_q[IDX_ENERGY] <= sat_sub(stat_q[IDX_ENERGY], COST_ENERGY);
            end
            default: ;
          endcase
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        ST_DECAY: begin
          for (int i = 0; i < NUM_STATS; i++) begin
            if (idx_q == 3'(i)) stat_q[i] <= sat_sub(stat_q[i], DECAY_STEP);
          end
          if (idx_q == DECAY_LAST) begin
            idx_q <= 3'd0;
            if (act.random[2:0] == 3'b000) begin
              state_q <= ST_EVENT;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end

        ST_EVENT: begin
          stat_q[IDX_HEALTH] <= sat_sub(stat_q[IDX_HEALTH], DECAY_STEP);
          state_q            <= ST_IDLE;
          busy_q             <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stat_scheduler.sv
// Randomized and directed checks of stat_scheduler against a queue-based work model.
module tb_stat_scheduler;

  localparam int PERIOD = 16;

  logic       clk;
  logic       reset;
  logic [3:0] hunger, happiness, health, hygiene, energy, social;
  logic       busy;
  logic       tick;

  stat_scheduler_if sif ();

  stat_scheduler #(.MAX_COUNT(24'd16)) dut (
    .clk       (clk),
    .reset     (reset),
    .act       (sif),
    .hunger    (hunger),
    .happiness (happiness),
    .health    (health),
    .hygiene   (hygiene),
    .energy    (energy),
    .social    (social),
    .busy      (busy),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One queued unit of work = one busy cycle; d holds signed per-stat deltas.
  typedef struct packed {
    logic            last_decay;
    logic [5:0][7:0] d;
  } work_t;

  work_t m_q[$];
  int    m_stat[6];
  bit    m_pend;
  bit    m_tick;
  int    m_edges;

  int checks;
  int errors;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp15(input int v);
    if (v < 0) return 0;
    if (v > 15) return 15;
    return v;
  endfunction

  function automatic logic [3:0] stat_out(input int k);
    case (k)
      0: return hunger;
      1: return happiness;
      2: return health;
      3: return hygiene;
      4: return energy;
      default: return social;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_stat[i] = 8;
    m_q.delete();
    m_pend  = 1'b0;
    m_tick  = 1'b0;
    m_edges = 0;
  endtask

  function automatic work_t action_work(input logic [2:0] id);
    work_t w;
    w = '0;
    case (id)
      3'd0: w.d[0] = 8'sd4;
      3'd1: begin w.d[1] = 8'sd4; w.d[4] = -8'sd1; end
      3'd2: w.d[2] = 8'sd4;
      3'd3: w.d[3] = 8'sd4;
      3'd4: w.d[4] = 8'sd6;
      3'd5: begin w.d[5] = 8'sd4; w.d[4] = -8'sd1; end
      default: ;
    endcase
    return w;
  endfunction

  // Advance the model across one rising edge using the inputs stable before it.
  task automatic model_step();
    bit    idle_in, pend_in, tick_in;
    work_t w;
    idle_in = (m_q.size() == 0);
    pend_in = m_pend;
    tick_in = m_tick;
    if (!idle_in) begin
      w = m_q.pop_front();
      for (int i = 0; i < 6; i++) m_stat[i] = clamp15(m_stat[i] + int'($signed(w.d[i])));
      if (w.last_decay && sif.random[2:0] == 3'b000) begin
        w = '0;
        w.d[2] = -8'sd1;
        m_q.push_back(w);
      end
    end else if (pend_in) begin
      for (int k = 0; k < 6; k++) begin
        w = '0;
        w.d[k] = -8'sd1;
        w.last_decay = (k == 5);
        m_q.push_back(w);
      end
    end else if (sif.action_valid) begin
      m_q.push_back(action_work(sif.action_id));
    end
    if (idle_in && pend_in) m_pend = 1'b0;
    else if (tick_in)       m_pend = 1'b1;
    m_edges++;
    m_tick = (m_edges % PERIOD == 0);
  endtask

  task automatic compare_all(input string tag);
    logic [23:0] exp_stats;
    exp_stats = {4'(m_stat[0]), 4'(m_stat[1]), 4'(m_stat[2]),
                 4'(m_stat[3]), 4'(m_stat[4]), 4'(m_stat[5])};
    check_eq({tag, ".stats"}, 32'({hunger, happiness, health, hygiene, energy, social}), 32'(exp_stats));
    check_eq({tag, ".busy"},  32'(busy), 32'(m_q.size() != 0));
    check_eq({tag, ".ready"}, 32'(sif.action_ready), 32'((m_q.size() == 0) && !m_pend));
    check_eq({tag, ".tick"},  32'(tick), 32'(m_tick));
  endtask

  task automatic do_cycle();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  // Called at a falling edge: assert reset mid-cycle, check at once, release a cycle later.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    sif.action_valid = 1'b0;
    sif.action_id    = 3'd0;
    sif.random       = 8'h01;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all("por");
    reset = 1'b0;

    // Feed twice back to back: 8 -> 12 -> 15 (saturated).
    sif.action_valid = 1'b1;
    sif.action_id    = 3'd0;
    run(2);
    check_eq("feed1.hunger", 32'(hunger), 32'd12);
    do_cycle();
    sif.action_valid = 1'b0;
    do_cycle();
    check_eq("feed2.hunger", 32'(hunger), 32'd15);

    // Idle decay: tick at edge 16, DECAY busy after edges 18..23, no event with random=01.
    apply_reset();
    sif.random = 8'h01;
    run(16);
    check_eq("decay.tick", 32'(tick), 32'd1);
    do_cycle();
    check_eq("decay.ready_pend", 32'(sif.action_ready), 32'd0);
    do_cycle();
    check_eq("decay.busy_on", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      do_cycle();
      check_eq($sformatf("decay.stat%0d", k), 32'(stat_out(k)), 32'd7);
      if (k < 5) check_eq($sformatf("decay.next%0d", k), 32'(stat_out(k + 1)), 32'd8);
    end
    check_eq("decay.busy_off", 32'(busy), 32'd0);
    check_eq("decay.health", 32'(health), 32'd7);

    // Sickness event on the last decay cycle.
    apply_reset();
    sif.random = 8'h08;
    run(24);
    check_eq("event.busy", 32'(busy), 32'd1);
    do_cycle();
    check_eq("event.health", 32'(health), 32'd6);
    check_eq("event.busy_off", 32'(busy), 32'd0);

    // Play accepted in the tick cycle: action first, decay right after.
    apply_reset();
    sif.random = 8'h01;
    run(16);
    sif.action_valid = 1'b1;
    sif.action_id    = 3'd1;
    do_cycle();
    sif.action_valid = 1'b0;
    do_cycle();
    check_eq("tickplay.happiness", 32'(happiness), 32'd12);
    check_eq("tickplay.energy", 32'(energy), 32'd7);
    check_eq("tickplay.ready", 32'(sif.action_ready), 32'd0);
    run(7);
    check_eq("tickplay.happiness2", 32'(happiness), 32'd11);
    check_eq("tickplay.energy2", 32'(energy), 32'd6);

    // Reset while the decay index is at hygiene.
    apply_reset();
    run(21);
    check_eq("middecay.health", 32'(health), 32'd7);
    check_eq("middecay.hygiene", 32'(hygiene), 32'd8);
    apply_reset();
    check_eq("middecay.rst_stats", 32'({hunger, happiness, health, hygiene, energy, social}), 32'h888888);
    do_cycle();
    check_eq("middecay.ready", 32'(sif.action_ready), 32'd1);

    // Starve every stat to 0 and keep ticking.
    run(16 * 10);
    check_eq("floor.stats", 32'({hunger, happiness, health, hygiene, energy, social}), 32'd0);
    run(16 * 3);
    check_eq("floor.stats2", 32'({hunger, happiness, health, hygiene, energy, social}), 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1600; n++) begin
      if (n < 800) sif.action_valid = ($urandom_range(0, 3) == 0);
      else         sif.action_valid = ($urandom_range(0, 3) != 0);
      sif.action_id = 3'($urandom_range(0, 7));
      sif.random    = 8'($urandom);
      if ($urandom_range(0, 299) == 0) apply_reset();
      else                             do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stat_scheduler.md
STAT_SCHEDULER -- requirements
Module: stat_scheduler

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 24'd10_000_000, giving clock cycles per decay tick (legal range 16..2^24-1).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port action_valid, input, 1 bit: player action request.
REQ-005 SHALL have port action_id, input, 3 bits: 0 feed, 1 play, 2 medicine, 3 clean, 4 sleep, 5 socialize, 6-7 no-op.
REQ-006 SHALL have port action_ready, output, 1 bit: the scheduler can accept an action this cycle.
REQ-007 SHALL have port random, input, 8 bits: LFSR value used for random events.
REQ-008 SHALL have ports hunger, happiness, health, hygiene, energy and social, each an output of 4 bits: stat registers, 0 worst, 15 best.
REQ-009 SHALL have port busy, output, 1 bit: FSM is not in IDLE.
REQ-010 SHALL have port tick, output, 1 bit: one-cycle decay-tick pulse.

Function
REQ-011 SHALL count 0..MAX_COUNT-1 and pulse tick in the cycle the count wraps.
REQ-012 SHALL set decay_pending on tick; a tick arriving while decay_pending is already set SHALL be dropped, never queued twice.
REQ-013 SHALL implement FSM states IDLE, ACTION, DECAY and EVENT, and SHALL be the only writer of the stat registers.
REQ-014 action_ready SHALL equal (state==IDLE) && !decay_pending.
REQ-015 In IDLE, the next state SHALL be chosen by priority: decay_pending -> DECAY, else action_valid&&action_ready -> ACTION (id latched), else stay in IDLE.
REQ-016 ACTION SHALL last exactly one cycle, apply the action and return to IDLE, so an accept at cycle N is visible on the outputs at N+2.
REQ-017 Action effects SHALL be: feed hunger+4; play happiness+4 and energy-1; medicine health+4; clean hygiene+4; sleep energy+6; socialize social+4 and energy-1; ids 6-7 are accepted with no change.
REQ-018 All stat arithmetic SHALL use 5-bit intermediates and saturate to 0..15, with no wrap-around.
REQ-019 DECAY SHALL last 6 cycles, with a 3-bit index 0..5 decrementing one stat per cycle in the order hunger, happiness, health, hygiene, energy, social; decay_pending SHALL clear on entry.
REQ-020 On the last DECAY cycle the block SHALL sample random: if random[2:0]==3'b000 it goes to EVENT, else to IDLE.
REQ-021 EVENT SHALL last one cycle, decrement health by 1 (saturating) and return to IDLE.
REQ-022 A tick in the same cycle as an IDLE accept SHALL let the action complete first, with DECAY following immediately after.
REQ-023 action_valid SHALL be ignored outside accept cycles; an action_valid held high SHALL be accepted again at every ready cycle.

Reset
REQ-024 On reset assertion, all stats SHALL immediately become 4'd8, the state IDLE, the counter, index and decay_pending 0, tick 0, busy 0 and action_ready 1.
REQ-025 A reset mid-DECAY or mid-ACTION SHALL abandon the operation with no partial update retained.

Structure
REQ-026 Package stat_pkg SHALL hold the FSM state enum, the action_id enum, the stat index constants, STAT_INIT=8, and the action gain constants.
REQ-027 One sub-module, tick_prescaler (parameter MAX_COUNT, ports clk, reset, tick), SHALL implement REQ-011.
REQ-028 The implementation SHALL be 120-400 lines of RTL, with no memories.

Verification (MAX_COUNT=16)
REQ-029 Reset then feed accepted at cycle N -> hunger 8->12 at N+2; a second feed -> hunger saturates at 15.
REQ-030 No actions for 16 cycles -> tick pulse, busy high for 6 cycles, every stat 8->7 in order hunger through social, one per cycle.
REQ-031 Tick and play accept in the same cycle -> happiness 12 and energy 7 first, then DECAY -> happiness 11, energy 6.
REQ-032 random=8'h08 on the last DECAY cycle -> EVENT entered and health ends at 6; random=8'h01 -> no EVENT, health ends at 7.
REQ-033 Reset asserted on DECAY index 3 -> all stats 8 immediately and state IDLE; action_ready high the next cycle.
REQ-034 All stats at 0 across repeated ticks -> they stay at 0 with no wrap; action_ready stays low while decay_pending is set.
